// File: rtl/alu_pkg.sv
// Purpose: shared definitions for the pipelined/sequential ALU: opcode encodings,
//          FSM state type, flag bundle and an opcode classification helper.
// Contents: OP_* opcode localparams, alu_state_t {IDLE, MUL}, alu_flags_t,
//           is_mul_op().
package alu_pkg;

  localparam logic [3:0] OP_EQ   = 4'b0000;
  localparam logic [3:0] OP_LT   = 4'b0001;
  localparam logic [3:0] OP_LTU  = 4'b0010;
  localparam logic [3:0] OP_GT   = 4'b0011;
  localparam logic [3:0] OP_GTU  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_ADD2 = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_OR   = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_MULL = 4'b1110;
  localparam logic [3:0] OP_MULH = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic negative;
    logic carry;
  } alu_flags_t;

  // Both multiply opcodes share the 111x prefix.
  function automatic logic is_mul_op(input logic [3:0] op);
    return op[3:1] == 3'b111;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Purpose: iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (aborts any product)
//   i_start        latch operands and begin (ignored bookkeeping-wise while running)
//   i_a, i_b       operands, sampled only when i_start is high
//   o_done         one-cycle pulse, o_prod valid in the same cycle
//   o_prod         full 2*WIDTH-bit product
module alu_seq_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_run;
  logic               r_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_mcand  <= {{WIDTH{1'b0}}, i_a};
        r_mplier <= i_b;
        r_acc    <= '0;
        r_cnt    <= CW'(WIDTH - 1);
        r_run    <= 1'b1;
      end else if (r_run) begin
        // Add the shifted multiplicand for each set multiplier bit, LSB first.
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_pipe_seq.sv
// Purpose: registered, valid/ready-handshaked ALU. Single-cycle ops (compare, add/sub,
//          shift, logic) have latency 1 at full throughput; MUL_LO/MUL_HI run on an
//          iterative multiplier and deliver WIDTH+1 cycles after accept.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready              request handshake (accept = in_valid & in_ready)
//   a, b, alu_cntrl, cin           operands, opcode, carry-in (ADD only)
//   out_valid/out_ready            result handshake
//   out, zero, overflow, negative, carry, illegal   registered result and flags
//   busy                           multiply in progress
module alu_pipe_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_cntrl,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow,
  output logic             negative,
  output logic             carry,
  output logic             illegal,
  output logic             busy
);

  import alu_pkg::*;

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_t         r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out;
  alu_flags_t         r_flags;
  logic               r_illegal;
  logic               r_mul_hi;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_load_single;
  logic               w_load_mul;
  logic               w_illegal;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_res;
  alu_flags_t         w_flags;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_mul_res;

  // Combinational only through out_ready; held low during reset so every output reads 0.
  assign in_ready = ~rst & (r_state == IDLE) & (~r_out_valid | out_ready);

  assign w_accept      = in_valid & in_ready;
  assign w_illegal     = is_mul_op(alu_cntrl) & ~MUL_EN;
  assign w_mul_start   = w_accept & is_mul_op(alu_cntrl) & MUL_EN;
  assign w_load_single = w_accept & ~w_mul_start;
  assign w_load_mul    = (r_state == MUL) & w_mul_done;

  assign w_add   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  // Carry out of a + ~b + 1 is the "no borrow" indication.
  assign w_sub   = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
  assign w_shamt = b[SHW-1:0];

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    case (alu_cntrl)
      OP_EQ:  w_flags.zero = (a == b);
      OP_LT:  w_flags.zero = ($signed(a) < $signed(b));
      OP_LTU: w_flags.zero = (a < b);
      OP_GT:  w_flags.zero = ($signed(a) > $signed(b));
      OP_GTU: w_flags.zero = (a > b);
      OP_ADD, OP_ADD2: begin
        w_res            = w_add[WIDTH-1:0];
        w_flags.carry    = w_add[WIDTH];
        w_flags.overflow = (a[MSB] == b[MSB]) & (w_add[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_res            = w_sub[WIDTH-1:0];
        w_flags.carry    = w_sub[WIDTH];
        w_flags.overflow = (a[MSB] != b[MSB]) & (w_sub[MSB] != a[MSB]);
      end
      OP_SLL: w_res = a << w_shamt;
      OP_SRL: w_res = a >> w_shamt;
      OP_SRA: w_res = $signed(a) >>> w_shamt;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_AND: w_res = a & b;
      // Multiplies never load from here; illegal ones load the all-zero default.
      default: w_res = '0;
    endcase
    w_flags.negative = w_res[MSB];
  end

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(w_mul_start),
    .i_a    (a),
    .i_b    (b),
    .o_done (w_mul_done),
    .o_prod (w_prod)
  );

  assign w_mul_res = r_mul_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_flags     <= '0;
      r_illegal   <= 1'b0;
      r_mul_hi    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mul_start) begin
            r_state  <= MUL;
            r_mul_hi <= (alu_cntrl == OP_MULH);
          end
        end
        MUL: begin
          if (w_mul_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A new result overrides the consume-clear of the previous one.
      if (w_load_single) begin
        r_out_valid <= 1'b1;
        r_out       <= w_res;
        r_flags     <= w_flags;
        r_illegal   <= w_illegal;
      end else if (w_load_mul) begin
        r_out_valid <= 1'b1;
        r_out       <= w_mul_res;
        r_flags     <= '{zero: 1'b0, overflow: 1'b0, negative: w_mul_res[MSB], carry: 1'b0};
        r_illegal   <= 1'b0;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign zero      = r_flags.zero;
  assign overflow  = r_flags.overflow;
  assign negative  = r_flags.negative;
  assign carry     = r_flags.carry;
  assign illegal   = r_illegal;
  assign busy      = (r_state == MUL);

endmodule

// File: tb/tb_alu_pipe_seq.sv
// Purpose: self-checking bench for alu_pipe_seq (WIDTH=32) with a MUL_EN=1 and a
//          MUL_EN=0 instance; directed corner cases plus randomized ops against an
//          arithmetic reference model.
module tb_alu_pipe_seq;

  localparam int unsigned W = 32;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_valid0, cin, out_ready;
  logic [W-1:0] a, b;
  logic [3:0]   op;

  logic         in_ready, out_valid, zero, overflow, negative, carry, illegal, busy;
  logic [W-1:0] out;
  logic         in_ready0, out_valid0, zero0, overflow0, negative0, carry0, illegal0, busy0;
  logic [W-1:0] out0;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .alu_cntrl(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .overflow(overflow), .negative(negative), .carry(carry),
    .illegal(illegal), .busy(busy)
  );

  alu_pipe_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .a(a), .b(b),
    .alu_cntrl(op), .cin(cin), .out_valid(out_valid0), .out_ready(out_ready), .out(out0),
    .zero(zero0), .overflow(overflow0), .negative(negative0), .carry(carry0),
    .illegal(illegal0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {out[31:0], zero, overflow, negative, carry, illegal}
  function automatic logic [36:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y, input logic ci,
                                        input bit mul_en);
    logic [W-1:0] r;
    logic         z, v, c, ill;
    longint       sx, sy, s;
    logic [63:0]  u;
    r = '0; z = 1'b0; v = 1'b0; c = 1'b0; ill = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      4'd0: z = (x == y);
      4'd1: z = (sx < sy);
      4'd2: z = (x < y);
      4'd3: z = (sx > sy);
      4'd4: z = (x > y);
      4'd5, 4'd6: begin
        u = 64'(x) + 64'(y) + 64'(ci);
        r = u[31:0];
        c = u[32];
        s = sx + sy + longint'(ci);
        v = (s > MAXI) || (s < MINI);
      end
      4'd7: begin
        u = 64'(x) - 64'(y);
        r = u[31:0];
        c = (x >= y);
        s = sx - sy;
        v = (s > MAXI) || (s < MINI);
      end
      4'd8:  r = x << y[4:0];
      4'd9:  r = x >> y[4:0];
      4'd10: r = W'($signed(x) >>> y[4:0]);
      4'd11: r = x | y;
      4'd12: r = x ^ y;
      4'd13: r = x & y;
      default: begin
        if (mul_en) begin
          u = 64'(x) * 64'(y);
          r = (o == 4'd14) ? u[31:0] : u[63:32];
        end else begin
          ill = 1'b1;
        end
      end
    endcase
    return {r, z, v, r[W-1], c, ill};
  endfunction

  task automatic chk_res(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci);
    chk(tag, {27'b0, out, zero, overflow, negative, carry, illegal},
        {27'b0, model(o, x, y, ci, 1'b1)});
  endtask

  // Present one request to dut, wait (bounded) for in_ready, return #1 after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci);
    op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
    for (int k = 0; k < 100 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    chk("issue_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called right after a multiply accept: scrambles inputs, then measures latency.
  task automatic wait_mul(input string tag, input logic [W-1:0] exp);
    int lat = 0;
    bit ok  = 1'b1;
    a = $urandom; b = $urandom; op = 4'($urandom); cin = 1'($urandom);
    while (!out_valid && lat < 60) begin
      ok &= (busy === 1'b1) && (in_ready === 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_busy_between"}, 64'(ok), 64'd1);
    chk({tag, "_out"}, 64'(out), 64'(exp));
    chk({tag, "_flags"}, {59'b0, zero, overflow, negative, carry, illegal},
        {59'b0, 1'b0, 1'b0, exp[W-1], 1'b0, 1'b0});
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x, y, e;
    logic [3:0]   o;
    logic         ci;
    bit           ok;

    rst = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {27'b0, out, out_valid, zero, overflow, negative, carry},
        64'd0);
    chk("reset_illegal_busy", {62'b0, illegal, busy}, 64'd0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);

    // ADD overflow into sign bit, latency 1
    issue(4'b0101, 32'h7FFF_FFFF, 32'h1, 1'b0);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_out", {27'b0, out, zero, overflow, negative, carry, illegal},
        {27'b0, 32'h8000_0000, 5'b01100});
    chk_res("add_model", 4'b0101, 32'h7FFF_FFFF, 32'h1, 1'b0);

    // SUB with borrow
    issue(4'b0111, 32'd5, 32'd7, 1'b1);
    chk("sub_out", {27'b0, out, zero, overflow, negative, carry, illegal},
        {27'b0, 32'hFFFF_FFFE, 5'b00100});

    // LTU vs LT on the same operands
    issue(4'b0010, 32'd1, 32'hFFFF_FFFF, 1'b0);
    chk("ltu_zero", {62'b0, zero, 1'(out == '0)}, 64'd3);
    issue(4'b0001, 32'd1, 32'hFFFF_FFFF, 1'b0);
    chk("lt_zero", 64'(zero), 64'd0);

    // Multiplies
    issue(4'b1111, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_mul("mulh", 32'h0000_0001);
    issue(4'b1110, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_mul("mull", 32'hFFFF_FFFE);

    // Drain, then stall the consumer on an SRA result
    @(posedge clk); #1;
    chk("drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    issue(4'b1010, 32'h8000_0000, 32'd4, 1'b0);
    chk("sra_out", {63'b0, out_valid}, 64'd1);
    chk("sra_val", 64'(out), 64'hF800_0000);
    op = 4'b0101; a = 32'd2; b = 32'd3; cin = 1'b0; in_valid = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ok &= (out === 32'hF800_0000) && (out_valid === 1'b1) && (in_ready === 1'b0) &&
            (negative === 1'b1);
      @(posedge clk); #1;
    end
    chk("stall_hold", 64'(ok), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("unstall_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("unstall_result", {31'b0, out, out_valid}, {31'b0, 32'd5, 1'b1});

    // Random single-cycle ops, back to back
    for (int i = 0; i < 60; i++) begin
      o  = 4'($urandom_range(0, 13));
      x  = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
      y  = (i % 5 == 0) ? x : $urandom;
      ci = 1'($urandom);
      op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
      chk("rand_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      chk("rand_valid", 64'(out_valid), 64'd1);
      chk_res("rand_res", o, x, y, ci);
    end
    in_valid = 1'b0;

    // Random multiplies
    for (int i = 0; i < 4; i++) begin
      o = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      x = $urandom; y = $urandom;
      e = model(o, x, y, 1'b0, 1'b1) >> 5;
      issue(o, x, y, 1'b0);
      wait_mul("rand_mul", e);
    end

    // Reset in the middle of a multiply
    issue(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midmul_rst_outs", {27'b0, out, out_valid, zero, overflow, negative, carry}, 64'd0);
    chk("midmul_rst_ib", {62'b0, illegal, busy}, 64'd0);
    #3;
    rst = 1'b0;
    #1;
    chk("midmul_release_ready", 64'(in_ready), 64'd1);
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      ok &= (out_valid === 1'b0) && (busy === 1'b0);
    end
    chk("midmul_no_stray", 64'(ok), 64'd1);

    // MUL_EN=0 instance: illegal multiply, then a normal ADD
    op = 4'b1111; a = $urandom; b = $urandom; cin = 1'b0; in_valid0 = 1'b1;
    chk("ill_ready", 64'(in_ready0), 64'd1);
    @(posedge clk); #1;
    op = 4'b0101; a = 32'd2; b = 32'd3;
    chk("ill_out", {26'b0, out0, out_valid0, zero0, overflow0, negative0, carry0, illegal0},
        {26'b0, 32'd0, 6'b100001});
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    chk("ill_add", {26'b0, out0, out_valid0, zero0, overflow0, negative0, carry0, illegal0},
        {26'b0, 32'd5, 6'b100000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
